rib_ex_bridge: RTL and testbench

- Sits between the core's execute-stage data port (rib_ex_addr/data/req/we) and a slower data bus that uses a request/acknowledge handshake with variable wait states.
- Captures each core access and drives it onto the bus with registered outputs.
- Stalls the pipeline through hold_flag_o, which feeds the core's rib_hold_flag_i, until the bus acknowledges the access or a timeout expires.
- Returns read data to the core, stable, in the release cycle.

---
 rtl/rib_ex_bridge.sv | 140 ++++++++++++++
 tb/tb_rib_ex_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_ex_bridge.sv
// rib_ex_bridge
//   Bridges the core execute-stage data port onto a request/acknowledge data
//   bus with variable wait states. One access is in flight at a time. The
//   core is stalled through hold_flag_o from the request cycle until the
//   access completes on the bus (ack) or is aborted after TIMEOUT wait cycles.
//   The release cycle (DONE) presents stable read data to the core.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   core_addr_i/wdata_i/we_i access description from the core
//   core_req_i               access request (combinational from core)
//   core_rdata_o             read data returned to the core
//   hold_flag_o              pipeline stall to the core
//   bus_addr_o/wdata_o/we_o  registered bus access description
//   bus_req_o                bus request, held until ack or timeout
//   bus_ack_i, bus_rdata_i   bus completion strobe and read data
//   err_o, err_addr_o        timeout abort pulse and aborted address
module rib_ex_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              hold_flag_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic              bus_we_o,
    output logic              bus_req_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    // Counter value seen in the TIMEOUT-th wait cycle (counter starts at 0).
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            eaddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            eaddr_q <= eaddr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;     // err is a single-cycle pulse
        eaddr_d     = eaddr_q;
        cnt_d       = cnt_q;
        hold_flag_o = 1'b0;
        case (state_q)
            IDLE: begin
                // Stall in the request cycle itself so the core cannot retire.
                hold_flag_o = core_req_i;
                if (core_req_i) begin
                    addr_d  = core_addr_i;
                    wdata_d = core_wdata_i;
                    we_d    = core_we_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // core_req_i is not looked at: a started access always finishes.
                hold_flag_o = 1'b1;
                cnt_d       = cnt_q + TO_W'(1);
                if (bus_ack_i) begin
                    // Ack takes priority over a coincident timeout.
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus_rdata_i;
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    eaddr_d = addr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Release cycle; core_req_i still belongs to the retiring access.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_rdata_o = rdata_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign bus_we_o     = we_q;
    assign bus_req_o    = req_q;
    assign err_o        = err_q;
    assign err_addr_o   = eaddr_q;

endmodule

// File: tb/tb_rib_ex_bridge.sv
// Bench for rib_ex_bridge: two instances share all inputs, one with a long
// timeout (16) and one with TIMEOUT=4. A transaction-level reference model
// tracks each instance and is compared on every cycle; directed table and
// sequences check the key scenarios against literal values.
module tb_rib_ex_bridge;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic [31:0] core_addr  = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] bus_rdata  = '0;
    logic        core_req   = 1'b0;
    logic        core_we    = 1'b0;
    logic        bus_ack    = 1'b0;

    logic [31:0] rdata_o [2];
    logic [31:0] baddr_o [2];
    logic [31:0] bwdata_o[2];
    logic [31:0] eaddr_o [2];
    logic        hold_o  [2];
    logic        bwe_o   [2];
    logic        breq_o  [2];
    logic        err_o   [2];

    rib_ex_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .TO_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_req_i(core_req), .core_we_i(core_we),
        .core_rdata_o(rdata_o[0]), .hold_flag_o(hold_o[0]),
        .bus_addr_o(baddr_o[0]), .bus_wdata_o(bwdata_o[0]),
        .bus_we_o(bwe_o[0]), .bus_req_o(breq_o[0]),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
        .err_o(err_o[0]), .err_addr_o(eaddr_o[0])
    );

    rib_ex_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TO_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_req_i(core_req), .core_we_i(core_we),
        .core_rdata_o(rdata_o[1]), .hold_flag_o(hold_o[1]),
        .bus_addr_o(baddr_o[1]), .bus_wdata_o(bwdata_o[1]),
        .bus_we_o(bwe_o[1]), .bus_req_o(breq_o[1]),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
        .err_o(err_o[1]), .err_addr_o(eaddr_o[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    // Reference model: one outstanding access, described by whether it is in
    // flight, how many wait cycles it has spent, and whether this is the
    // release cycle after it ended.
    typedef struct {
        bit          busy;
        bit          done;
        int          waited;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] eaddr;
    } mdl_t;

    mdl_t m[2];
    int   tmo[2] = '{16, 4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m[i].busy = 0; m[i].done = 0; m[i].waited = 0;
        m[i].addr = '0; m[i].wdata = '0; m[i].we = 0;
        m[i].rdata = '0; m[i].err = 0; m[i].eaddr = '0;
    endtask

    // Applied at each rising edge with the inputs of the cycle just ended.
    task automatic model_update(input int i);
        if (!rst) begin
            model_reset(i);
        end else if (m[i].done) begin
            m[i].done = 0;
            m[i].err  = 0;
        end else if (m[i].busy) begin
            m[i].waited++;
            m[i].err = 0;
            if (bus_ack) begin
                m[i].busy = 0;
                m[i].done = 1;
                if (!m[i].we) m[i].rdata = bus_rdata;
            end else if (m[i].waited == tmo[i]) begin
                m[i].busy  = 0;
                m[i].done  = 1;
                m[i].rdata = '0;
                m[i].err   = 1;
                m[i].eaddr = m[i].addr;
            end
        end else begin
            m[i].err = 0;
            if (core_req) begin
                m[i].busy   = 1;
                m[i].waited = 0;
                m[i].addr   = core_addr;
                m[i].wdata  = core_wdata;
                m[i].we     = core_we;
            end
        end
    endtask

    task automatic model_check(input int i);
        logic exp_hold;
        exp_hold = m[i].busy ? 1'b1 : (m[i].done ? 1'b0 : core_req);
        chk($sformatf("dut%0d hold", i),  32'(hold_o[i]), 32'(exp_hold));
        chk($sformatf("dut%0d breq", i),  32'(breq_o[i]), 32'(m[i].busy));
        chk($sformatf("dut%0d baddr", i), baddr_o[i], m[i].addr);
        chk($sformatf("dut%0d bwdata", i), bwdata_o[i], m[i].wdata);
        chk($sformatf("dut%0d bwe", i),   32'(bwe_o[i]), 32'(m[i].we));
        chk($sformatf("dut%0d rdata", i), rdata_o[i], m[i].rdata);
        chk($sformatf("dut%0d err", i),   32'(err_o[i]), 32'(m[i].err));
        chk($sformatf("dut%0d eaddr", i), eaddr_o[i], m[i].eaddr);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input bit r, input bit rq, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input bit ak, input logic [31:0] rd);
        rst = r; core_req = rq; core_we = we; core_addr = a;
        core_wdata = wd; bus_ack = ak; bus_rdata = rd;
        #1;
    endtask

    task automatic tick();
        if (model_on) begin
            model_check(0);
            model_check(1);
        end
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
    endtask

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        bit          ack;
        logic [31:0] brd;
        bit          e_hold;
        bit          e_breq;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int hold_cnt;
        model_reset(0);
        model_reset(1);

        // Read with ack in the first wait cycle, then a back-to-back read in
        // the cycle after DONE, then a spurious ack in IDLE.
        tbl[0] = '{1, 0, 32'h1000_0004, 0, 32'h0,         1, 0, 32'h0};
        tbl[1] = '{1, 0, 32'h1000_0004, 1, 32'hDEAD_BEEF, 1, 1, 32'h0};
        tbl[2] = '{1, 0, 32'h1000_0004, 0, 32'h0,         0, 0, 32'hDEAD_BEEF};
        tbl[3] = '{1, 0, 32'h1000_0008, 0, 32'h0,         1, 0, 32'hDEAD_BEEF};
        tbl[4] = '{1, 0, 32'h1000_0008, 1, 32'hCAFE_F00D, 1, 1, 32'hDEAD_BEEF};
        tbl[5] = '{1, 0, 32'h1000_0008, 0, 32'h0,         0, 0, 32'hCAFE_F00D};
        tbl[6] = '{0, 0, 32'h0,         1, 32'h1111_1111, 0, 0, 32'hCAFE_F00D};
        tbl[7] = '{0, 0, 32'h0,         0, 32'h0,         0, 0, 32'hCAFE_F00D};

        @(negedge clk);
        drive(0, 0, 0, '0, '0, 0, '0);
        tick();
        tick();
        model_on = 1'b1;

        // Reset state
        drive(1, 0, 0, '0, '0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            chk("rst hold",  32'(hold_o[i]), 32'h0);
            chk("rst breq",  32'(breq_o[i]), 32'h0);
            chk("rst bwe",   32'(bwe_o[i]),  32'h0);
            chk("rst baddr", baddr_o[i],     32'h0);
            chk("rst rdata", rdata_o[i],     32'h0);
            chk("rst err",   32'(err_o[i]),  32'h0);
            chk("rst eaddr", eaddr_o[i],     32'h0);
        end
        tick();

        // Table: reads, back-to-back, spurious ack
        for (int k = 0; k < 8; k++) begin
            drive(1, tbl[k].req, tbl[k].we, tbl[k].addr, '0, tbl[k].ack, tbl[k].brd);
            chk($sformatf("tbl%0d hold", k),  32'(hold_o[0]), 32'(tbl[k].e_hold));
            chk($sformatf("tbl%0d breq", k),  32'(breq_o[0]), 32'(tbl[k].e_breq));
            chk($sformatf("tbl%0d rdata", k), rdata_o[0],     tbl[k].e_rdata);
            tick();
        end

        // Write with 5 wait states on the long-timeout instance
        hold_cnt = 0;
        drive(1, 1, 1, 32'h2000_0000, 32'h1234_5678, 0, '0);
        hold_cnt += int'(hold_o[0]);
        tick();
        for (int k = 1; k <= 6; k++) begin
            drive(1, 1, 1, 32'h2000_0000, 32'h1234_5678, k == 6, 32'h9999_9999);
            hold_cnt += int'(hold_o[0]);
            chk("wr baddr",  baddr_o[0],     32'h2000_0000);
            chk("wr bwdata", bwdata_o[0],    32'h1234_5678);
            chk("wr bwe",    32'(bwe_o[0]),  32'h1);
            chk("wr breq",   32'(breq_o[0]), 32'h1);
            tick();
        end
        drive(1, 1, 1, 32'h2000_0000, 32'h1234_5678, 0, '0);
        hold_cnt += int'(hold_o[0]);
        chk("wr hold cycles", 32'(hold_cnt), 32'd7);
        chk("wr rdata kept",  rdata_o[0], 32'hCAFE_F00D);
        chk("wr breq done",   32'(breq_o[0]), 32'h0);
        tick();
        drive(1, 0, 0, '0, '0, 0, '0);
        for (int k = 0; k < 10; k++) tick();

        // Timeout on the TIMEOUT=4 instance
        drive(1, 1, 0, 32'h3000_00C0, '0, 0, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 0, 32'h3000_00C0, '0, 0, '0);
            chk("to breq", 32'(breq_o[1]), 32'h1);
            chk("to err",  32'(err_o[1]),  32'h0);
            chk("to hold", 32'(hold_o[1]), 32'h1);
            tick();
        end
        drive(1, 0, 0, '0, '0, 0, '0);
        chk("to done breq",  32'(breq_o[1]), 32'h0);
        chk("to done err",   32'(err_o[1]),  32'h1);
        chk("to done hold",  32'(hold_o[1]), 32'h0);
        chk("to done rdata", rdata_o[1],     32'h0);
        chk("to done eaddr", eaddr_o[1],     32'h3000_00C0);
        tick();
        chk("to err pulse", 32'(err_o[1]), 32'h0);
        for (int k = 0; k < 20; k++) tick();

        // Ack on the final timeout cycle: ack wins
        drive(1, 1, 0, 32'h4000_0010, '0, 0, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 0, 32'h4000_0010, '0, k == 4, 32'hA5A5_5A5A);
            tick();
        end
        drive(1, 0, 0, '0, '0, 0, '0);
        chk("late ack err",   32'(err_o[1]), 32'h0);
        chk("late ack rdata", rdata_o[1],    32'hA5A5_5A5A);
        chk("late ack eaddr", eaddr_o[1],    32'h3000_00C0);
        chk("late ack hold",  32'(hold_o[1]), 32'h0);
        tick();
        chk("late ack err2", 32'(err_o[1]), 32'h0);
        tick();

        // Reset in the middle of an access, then a stray ack
        drive(1, 1, 0, 32'h5000_0000, '0, 0, '0);
        tick();
        tick();
        tick();
        drive(0, 1, 0, 32'h5000_0000, '0, 0, '0);
        chk("mid rst hold", 32'(hold_o[0]), 32'h1);
        tick();
        drive(1, 0, 0, '0, '0, 0, '0);
        chk("post rst breq",  32'(breq_o[0]), 32'h0);
        chk("post rst hold",  32'(hold_o[0]), 32'h0);
        chk("post rst baddr", baddr_o[0],     32'h0);
        chk("post rst rdata", rdata_o[0],     32'h0);
        chk("post rst eaddr", eaddr_o[1],     32'h0);
        chk("post rst err",   32'(err_o[0]),  32'h0);
        tick();
        drive(1, 0, 0, '0, '0, 1, 32'hFFFF_FFFF);
        tick();
        drive(1, 0, 0, '0, '0, 0, '0);
        chk("stray ack rdata", rdata_o[0],     32'h0);
        chk("stray ack breq",  32'(breq_o[0]), 32'h0);
        chk("stray ack err",   32'(err_o[0]),  32'h0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom, $urandom,
                  $urandom_range(0, 5) == 0, $urandom);
            tick();
        end
        drive(1, 0, 0, '0, '0, 0, '0);
        for (int k = 0; k < 20; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
